// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the controller state encoding and the datapath widths.
package mult_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_32_bit.sv
// Plain 32-bit ripple-carry adder with no carry in or carry out.
// Callers that need the carry out recover it from the operand and sum MSBs.
module adder_32_bit (
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  output logic [31:0] sum
);

  logic [31:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i] = i1[i] ^ i2[i] ^ carry[i];
    if (i < 31) begin : g_carry
      assign carry[i+1] = (i1[i] & i2[i]) | (carry[i] & (i1[i] ^ i2[i]));
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier, one partial-product add per clock.
// A single shared adder_32_bit performs every add; its missing carry out is rebuilt here.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state_q;
  state_t               state_d;
  logic                 accept;
  logic                 iterate;
  logic [CNT_W-1:0]     count_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   p_q;

  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_carry;

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    accept  = 1'b0;
    iterate = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        iterate = 1'b1;
        if (count_q == LAST_ITER) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Partial-product add: the multiplicand is gated to zero when the current multiplier bit is 0.
  assign add_a = p_q[2*WIDTH-1:WIDTH];
  assign add_b = p_q[0] ? mcand_q : '0;

  adder_32_bit u_adder (
    .i1  (add_a),
    .i2  (add_b),
    .sum (add_sum)
  );

  // Carry out of bit WIDTH-1: both MSBs set, or exactly one set and the sum MSB wrapped to 0.
  assign add_carry = (add_a[WIDTH-1] & add_b[WIDTH-1])
                   | ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);

  always_ff @(posedge clk) begin
    // NOTE: every datapath register is cleared on reset so an aborted operation leaves no stale product.
    if (reset) begin
      count_q <= '0;
      mcand_q <= '0;
      p_q     <= '0;
    end else if (accept) begin
      count_q <= '0;
      mcand_q <= multiplicand;
      p_q     <= {{WIDTH{1'b0}}, multiplier};
    end else if (iterate) begin
      count_q <= count_q + 1'b1;
      p_q     <= {add_carry, add_sum, p_q[WIDTH-1:1]};
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = p_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: vector table, handshake corner sequences, random pairs.
// Expected products come from constants or a plain 64-bit A*B reference.
module tb_mult_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_checks;
  int n_fail;

  mult_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'h0, a};
    wb = {32'h0, b};
    return wa * wb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 of an operation; returns in cycle 33 with done checked.
  // hold keeps start high with random operands; repulse pulses a 2*2 start in that cycle.
  task automatic wait_result(input string tag, input logic [63:0] exp,
                             input bit hold, input int repulse);
    int bad;
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (c == repulse) begin
        start = 1'b1;
        multiplicand = 32'd2;
        multiplier   = 32'd2;
      end else begin
        start = hold;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      tick();
    end
    start = hold;
    check({tag, " busy_window"}, 64'(bad), 64'd0);
    check({tag, " done"}, {62'd0, busy, done}, 64'd1);
    check({tag, " product"}, product, exp);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int repulse);
    start = 1'b1;
    multiplicand = a;
    multiplier   = b;
    tick();
    start = 1'b0;
    wait_result(tag, exp, 1'b0, repulse);
    tick();
    check({tag, " idle_after"}, {62'd0, busy, done}, 64'd0);
    check({tag, " product_held"}, product, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          bad;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{32'd3,          32'd5,          64'd15,                   "3x5"};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001,  "max_x_max"};
    vecs[2] = '{32'd0,          32'hDEAD_BEEF,  64'd0,                    "0_x_deadbeef"};
    vecs[3] = '{32'hDEAD_BEEF,  32'd0,          64'd0,                    "deadbeef_x_0"};
    vecs[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF,  "1_x_max"};
    vecs[5] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF,  "max_x_1"};
    vecs[6] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000,  "msb_x_msb"};
    vecs[7] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000,  "2p16_sq"};

    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    check("reset flags", {62'd0, busy, done}, 64'd0);
    check("reset product", product, 64'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
    end

    // Start re-pulsed while busy must be ignored.
    run_op("repulse_7x9", 32'd7, 32'd9, 64'd63, 10);

    // Reset in cycle 15 aborts the operation without a done pulse.
    start = 1'b1;
    multiplicand = 32'h1234;
    multiplier   = 32'h5678;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort flags", {62'd0, busy, done}, 64'd0);
    check("abort product", product, 64'd0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy !== 1'b0 || done !== 1'b0) bad++;
      tick();
    end
    check("abort no_done", 64'(bad), 64'd0);
    run_op("after_abort", 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000, 0);

    // Start held high through S_DONE: back-to-back operations with no idle gap.
    start = 1'b1;
    multiplicand = 32'd6;
    multiplier   = 32'd7;
    tick();
    wait_result("b2b_first", 64'd42, 1'b1, 0);
    multiplicand = 32'h8000_0000;
    multiplier   = 32'd2;
    tick();
    start = 1'b0;
    wait_result("b2b_second", 64'h1_0000_0000, 1'b0, 0);
    tick();
    check("b2b idle_after", {62'd0, busy, done}, 64'd0);

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 8 == 0) ra = ra >> $urandom_range(31, 0);
      if (n % 8 == 1) rb = rb >> $urandom_range(31, 0);
      run_op($sformatf("rand%0d %h*%h", n, ra, rb), ra, rb, ref_mul(ra, rb), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
